// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Machine-mode trap sequencer. Takes synchronous exceptions,
//                pending interrupts and mret, writes mepc/mcause through the
//                CSR direct-write ports, redirects fetch to mtvec or mepc and
//                stalls the pipeline while a trap or return is in flight.
//                Owns the global interrupt enable (MIE) and its saved copy.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter logic RESET_MIE = 1'b0,
    parameter int   CAUSE_W   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               excReq,
    input  logic [CAUSE_W-1:0] excCause,
    input  logic [31:0]        excPc,
    input  logic [31:0]        nextPc,
    input  logic               boundary,
    input  logic               mret,
    input  logic               irqExt,
    input  logic               irqTimer,
    input  logic               mieWe,
    input  logic               mieDi,
    input  logic [31:0]        mtvecDo,
    input  logic [31:0]        mepcDo,
    output logic               mepcWe,
    output logic [31:0]        mepcDi,
    output logic               mcauseWe,
    output logic [31:0]        mcauseDi,
    output logic               redirect,
    output logic [31:0]        redirectPc,
    output logic               stall,
    output logic               mieOut
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_JUMP = 2'd2,
        ST_RET  = 2'd3
    } state_t;

    // Interrupt cause codes; external wins over timer when both pend.
    localparam logic [CAUSE_W-1:0] c_CAUSE_EXT   = CAUSE_W'(11);
    localparam logic [CAUSE_W-1:0] c_CAUSE_TIMER = CAUSE_W'(7);

    state_t               state_q,  state_d;
    logic                 mie_q,    mie_d;
    logic                 mpie_q,   mpie_d;
    logic [31:0]          epc_q,    epc_d;
    logic [CAUSE_W-1:0]   cause_q,  cause_d;
    logic                 is_irq_q, is_irq_d;

    logic                 w_irq_take;
    logic [31:0]          w_tvec_base;
    logic [31:0]          w_tvec_off;

    // Interrupt gating uses the registered MIE, so a same-cycle mieWe
    // does not affect whether an interrupt is taken this cycle.
    assign w_irq_take  = boundary & mie_q & (irqExt | irqTimer);
    assign w_tvec_base = {mtvecDo[31:2], 2'b00};
    assign w_tvec_off  = {{(30 - CAUSE_W){1'b0}}, cause_q, 2'b00};

    // State and held trap context; reset aborts any sequence in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mie_q    <= RESET_MIE;
            mpie_q   <= 1'b0;
            epc_q    <= 32'd0;
            cause_q  <= '0;
            is_irq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            is_irq_q <= is_irq_d;
        end
    end

    // Next-state logic and outputs decoded from the current state.
    always_comb begin
        state_d    = state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        is_irq_d   = is_irq_q;
        mepcWe     = 1'b0;
        mepcDi     = 32'd0;
        mcauseWe   = 1'b0;
        mcauseDi   = 32'd0;
        redirect   = 1'b0;
        redirectPc = 32'd0;
        stall      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mieWe) begin
                    mie_d = mieDi;
                end
                if (excReq) begin
                    state_d  = ST_SAVE;
                    epc_d    = excPc;
                    cause_d  = excCause;
                    is_irq_d = 1'b0;
                end else if (mret) begin
                    state_d = ST_RET;
                end else if (w_irq_take) begin
                    state_d  = ST_SAVE;
                    epc_d    = nextPc;
                    cause_d  = irqExt ? c_CAUSE_EXT : c_CAUSE_TIMER;
                    is_irq_d = 1'b1;
                end
            end
            ST_SAVE: begin
                stall    = 1'b1;
                mepcWe   = 1'b1;
                mepcDi   = epc_q;
                mcauseWe = 1'b1;
                mcauseDi = {is_irq_q, {(31 - CAUSE_W){1'b0}}, cause_q};
                // Trap entry clear overrides any software write this cycle.
                mpie_d   = mie_q;
                mie_d    = 1'b0;
                state_d  = ST_JUMP;
            end
            ST_JUMP: begin
                stall    = 1'b1;
                redirect = 1'b1;
                // Only mode 1 with an interrupt vectors; everything else goes to base.
                if ((mtvecDo[1:0] == 2'b01) && is_irq_q) begin
                    redirectPc = w_tvec_base + w_tvec_off;
                end else begin
                    redirectPc = w_tvec_base;
                end
                if (mieWe) begin
                    mie_d = mieDi;
                end
                state_d = ST_IDLE;
            end
            ST_RET: begin
                stall      = 1'b1;
                redirect   = 1'b1;
                redirectPc = mepcDo;
                // MPIE restore overrides any software write this cycle.
                mie_d      = mpie_q;
                mpie_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mieOut = mie_q;

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer for the machine-mode CSR file. It detects synchronous exceptions, pending interrupts and mret. It drives the CSR direct-write ports (mepcWe/mepcDi, mcauseWe/mcauseDi), computes the redirect PC from mtvec or mepc, and stalls the pipeline while a trap or return is in progress. It also owns the global interrupt-enable bit (MIE) and its saved copy (MPIE).

Parameters:
RESET_MIE, 0, value of MIE after reset
CAUSE_W, 5, width of exception/interrupt cause code

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
excReq  in  1  synchronous exception raised by the current instruction
excCause  in  CAUSE_W  exception code, valid with excReq
excPc  in  32  PC of the faulting instruction
nextPc  in  32  PC of the next instruction to execute; saved on interrupt entry
boundary  in  1  instruction boundary; interrupts may be taken this cycle
mret  in  1  mret is executing
irqExt  in  1  external interrupt pending (level)
irqTimer  in  1  timer interrupt pending (level)
mieWe  in  1  software write to MIE
mieDi  in  1  new MIE value
mtvecDo  in  32  current mtvec from the CSR file
mepcDo  in  32  current mepc from the CSR file
mepcWe  out  1  mepc write strobe
mepcDi  out  32  mepc write data
mcauseWe  out  1  mcause write strobe
mcauseDi  out  32  mcause write data
redirect  out  1  fetch redirect strobe
redirectPc  out  32  redirect target
stall  out  1  freeze pipeline
mieOut  out  1  current MIE

Behaviour:
- States: IDLE, SAVE, JUMP, RET. Outputs are decoded combinationally from state and held registers.
- Reset (async): state=IDLE, MIE=RESET_MIE, MPIE=0, held cause/epc/isIrq=0. All strobes and stall go to 0 immediately, including mid-sequence; no write or redirect follows the reset.
- IDLE, priority order:
  1. excReq -> SAVE. Latch epc=excPc, cause=excCause, isIrq=0.
  2. else mret -> RET.
  3. else boundary & MIE & (irqExt|irqTimer) -> SAVE. Latch epc=nextPc, isIrq=1, cause=11 if irqExt else 7 (external beats timer).
  4. else stay in IDLE.
- SAVE (1 cycle):
  - mepcWe=1, mepcDi=epc, mcauseWe=1, mcauseDi={isIrq, zero fill, cause}.
  - MPIE<=MIE, MIE<=0.
  - -> JUMP.
- JUMP (1 cycle):
  - redirect=1.
  - redirectPc={mtvecDo[31:2],2'b00} when mtvecDo[1:0]==0 or isIrq==0.
  - redirectPc={mtvecDo[31:2],2'b00}+4*cause when mtvecDo[1:0]==1 and isIrq==1.
  - 32-bit wrap on the addition.
  - -> IDLE.
- RET (1 cycle): redirect=1, redirectPc=mepcDo, MIE<=MPIE, MPIE<=1, -> IDLE.
- stall=1 in SAVE, JUMP and RET; stall=0 in IDLE.
- Trap-entry latency: request in IDLE at cycle N; CSR write at N+1; redirect at N+2; first handler fetch at N+3.
- Return latency: mret at cycle N; redirect at N+1.
- Requests (excReq, mret, irq*) outside IDLE are ignored. Requesters must hold or re-raise them; the pipeline is stalled.
- mieWe applies in IDLE and JUMP. In SAVE the trap-entry clear wins; in RET the MPIE restore wins.
- mieWe in the same IDLE cycle as an interrupt: the gating uses the old MIE.
- mepcWe/mcauseWe have priority over software CSR writes inside the CSR file. The controller does not arbitrate them.

Test Plan:
1. Reset mid-sequence: assert reset while in SAVE -> mepcWe=0, stall=0 immediately, no redirect afterwards, mieOut=RESET_MIE.
2. Exception, direct mode: excReq, excCause=2, excPc=0x100, mtvec=0x200 -> next cycle mepcDi=0x100, mcauseDi=0x00000002; following cycle redirect=1, redirectPc=0x200; mieOut=0.
3. Vectored interrupt: MIE=1, mtvec=0x201, irqTimer and boundary, nextPc=0x40 -> mcauseDi=0x80000007, mepcDi=0x40, redirectPc=0x21C.
4. Simultaneous sources:
   - excReq+mret+irqExt together -> exception taken, mcauseDi MSB=0.
   - irqExt+irqTimer together -> cause 11.
5. Interrupt masking: MIE=0 with irqExt held -> no trap. Then mieWe=1, mieDi=1 -> trap on the next boundary cycle.
6. mret after trap entry: mepc=0x104 -> redirectPc=0x104 one cycle after mret; MIE restored to 1 (pre-trap value); stall high for exactly 1 cycle.
